// File: rtl/cond_pkg.sv
// Shared definitions for the conditional-control pipeline: ARM condition codes,
// NZCV flag bit positions and FlagWrite bit positions.
package cond_pkg;

    typedef enum logic [3:0] {
        COND_EQ = 4'b0000,
        COND_NE = 4'b0001,
        COND_CS = 4'b0010,
        COND_CC = 4'b0011,
        COND_MI = 4'b0100,
        COND_PL = 4'b0101,
        COND_VS = 4'b0110,
        COND_VC = 4'b0111,
        COND_HI = 4'b1000,
        COND_LS = 4'b1001,
        COND_GE = 4'b1010,
        COND_LT = 4'b1011,
        COND_GT = 4'b1100,
        COND_LE = 4'b1101,
        COND_AL = 4'b1110,
        COND_NV = 4'b1111
    } cond_e;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    localparam int FW_NZ = 1;
    localparam int FW_CV = 0;

endpackage

// File: rtl/cond_eval.sv
// Combinational ARM condition evaluator: Cond against NZCV Flags.
module cond_eval
    import cond_pkg::*;
(
    input  logic [3:0] Cond,
    input  logic [3:0] Flags,
    output logic       CondEx
);

    logic n, z, c, v;

    assign n = Flags[FLAG_N];
    assign z = Flags[FLAG_Z];
    assign c = Flags[FLAG_C];
    assign v = Flags[FLAG_V];

    always_comb begin
        CondEx = 1'b1;
        case (cond_e'(Cond))
            COND_EQ: CondEx = z;
            COND_NE: CondEx = ~z;
            COND_CS: CondEx = c;
            COND_CC: CondEx = ~c;
            COND_MI: CondEx = n;
            COND_PL: CondEx = ~n;
            COND_VS: CondEx = v;
            COND_VC: CondEx = ~v;
            COND_HI: CondEx = c & ~z;
            COND_LS: CondEx = ~c | z;
            COND_GE: CondEx = ~(n ^ v);
            COND_LT: CondEx = n ^ v;
            COND_GT: CondEx = ~z & ~(n ^ v);
            COND_LE: CondEx = z | (n ^ v);
            default: CondEx = 1'b1;
        endcase
    end

endmodule

// File: rtl/cond_ctrl_pipe.sv
// Conditional control-bundle pipeline with NZCV flag register and PC-write tracking.
// Define COND_EARLY_BRANCH_EN to resolve branches in D against the next-cycle flags.
module cond_ctrl_pipe
    import cond_pkg::*;
#(
    parameter int          CTRL_W    = 8,
    parameter int          DEPTH     = 3,
    parameter logic [31:0] GATE_MASK = 32'h0000_000F,
    parameter int          PC_BIT    = 0,
    parameter int          BR_BIT    = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          StallE,
    input  logic                          FlushE,
    input  logic [CTRL_W-1:0]             CtrlD,
    input  logic [3:0]                    CondD,
    input  logic [1:0]                    FlagWriteD,
    input  logic [3:0]                    ALUFlagsE,
    output logic [CTRL_W-1:0]             CtrlE,
    output logic [(DEPTH-1)*CTRL_W-1:0]   CtrlPipe,
    output logic                          CondExE,
    output logic [3:0]                    FlagsE,
    output logic                          BranchTakenD,
    output logic                          PCWrPendingF
);

    if (CTRL_W < 4 || CTRL_W > 32 || DEPTH < 2 || DEPTH > 8 ||
        PC_BIT < 0 || PC_BIT >= CTRL_W || BR_BIT < 0 || BR_BIT >= CTRL_W) begin : g_bad_params
        $error("cond_ctrl_pipe: illegal parameter combination");
    end

    localparam logic [CTRL_W-1:0] GATE_W = GATE_MASK[CTRL_W-1:0];

    logic [CTRL_W-1:0] ctrl_e_q, ctrl_e_d;
    logic [3:0]        cond_e_q, cond_e_d;
    logic [1:0]        fw_e_q, fw_e_d;
    logic [3:0]        flags_q, flags_d;
    logic              cond_ex_e;
    logic [CTRL_W-1:0] gated_e;
    logic [CTRL_W-1:0] stage_q [1:DEPTH-1];
    logic [CTRL_W-1:0] stage_d [1:DEPTH-1];
    logic [DEPTH-1:0]  pc_bits;

    // Flush wins over stall: a flushed slot must become a bubble even when held.
    always_comb begin
        ctrl_e_d = ctrl_e_q;
        cond_e_d = cond_e_q;
        fw_e_d   = fw_e_q;
        if (FlushE) begin
            ctrl_e_d = '0;
            cond_e_d = '0;
            fw_e_d   = '0;
        end else if (!StallE) begin
            ctrl_e_d = CtrlD;
            cond_e_d = CondD;
            fw_e_d   = FlagWriteD;
        end
    end

    cond_eval u_cond_e (
        .Cond   (cond_e_q),
        .Flags  (flags_q),
        .CondEx (cond_ex_e)
    );

    always_comb begin
        flags_d = flags_q;
        if (cond_ex_e && fw_e_q[FW_NZ]) begin
            flags_d[FLAG_N] = ALUFlagsE[FLAG_N];
            flags_d[FLAG_Z] = ALUFlagsE[FLAG_Z];
        end
        if (cond_ex_e && fw_e_q[FW_CV]) begin
            flags_d[FLAG_C] = ALUFlagsE[FLAG_C];
            flags_d[FLAG_V] = ALUFlagsE[FLAG_V];
        end
    end

    assign gated_e = ctrl_e_q & ~(GATE_W & {CTRL_W{~cond_ex_e}});

    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_e_q <= '0;
            cond_e_q <= '0;
            fw_e_q   <= '0;
            flags_q  <= '0;
        end else begin
            ctrl_e_q <= ctrl_e_d;
            cond_e_q <= cond_e_d;
            fw_e_q   <= fw_e_d;
            if (!StallE) begin
                flags_q <= flags_d;
            end
        end
    end

    assign pc_bits[0] = CtrlD[PC_BIT] | ctrl_e_q[PC_BIT];

    for (genvar gi = 1; gi < DEPTH; gi++) begin : g_stage
        if (gi == 1) begin : g_first
            // A held stage 0 must not be duplicated downstream, so stage 1 takes a bubble.
            assign stage_d[gi] = (StallE && !FlushE) ? '0 : gated_e;
        end else begin : g_rest
            assign stage_d[gi] = stage_q[gi-1];
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                stage_q[gi] <= '0;
            end else begin
                stage_q[gi] <= stage_d[gi];
            end
        end

        assign CtrlPipe[(gi-1)*CTRL_W +: CTRL_W] = stage_q[gi];

        if (gi < DEPTH - 1) begin : g_pc
            assign pc_bits[gi] = stage_q[gi][PC_BIT];
        end else begin : g_pc_last
            assign pc_bits[gi] = 1'b0;
        end
    end

    assign CtrlE        = ctrl_e_q;
    assign CondExE      = cond_ex_e;
    assign FlagsE       = flags_q;
    assign PCWrPendingF = |pc_bits;

`ifdef COND_EARLY_BRANCH_EN
    logic cond_ex_d;

    cond_eval u_cond_d (
        .Cond   (CondD),
        .Flags  (flags_d),
        .CondEx (cond_ex_d)
    );

    assign BranchTakenD = CtrlD[BR_BIT] & cond_ex_d;
`else
    assign BranchTakenD = 1'b0;
`endif

endmodule

// File: tb/tb_cond_ctrl_pipe.sv
// Directed self-checking bench for cond_ctrl_pipe (DEPTH=3 default, plus DEPTH=2/8 at CTRL_W=16).
module tb_cond_ctrl_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic        StallE;
    logic        FlushE;
    logic [7:0]  CtrlD;
    logic [15:0] CtrlD16;
    logic [3:0]  CondD;
    logic [1:0]  FlagWriteD;
    logic [3:0]  ALUFlagsE;

    logic [7:0]   d3_ctrl_e;
    logic [15:0]  d3_pipe;
    logic         d3_cond, d3_br, d3_pend;
    logic [3:0]   d3_flags;
    logic [15:0]  d2_ctrl_e;
    logic [15:0]  d2_pipe;
    logic         d2_cond, d2_br, d2_pend;
    logic [3:0]   d2_flags;
    logic [15:0]  d8_ctrl_e;
    logic [111:0] d8_pipe;
    logic         d8_cond, d8_br, d8_pend;
    logic [3:0]   d8_flags;

    int total_cnt = 0;
    int bad_cnt   = 0;
    logic exp_br;

    assign CtrlD16 = {8'h00, CtrlD};

    always #5 clk = ~clk;

    cond_ctrl_pipe u_d3 (
        .clk(clk), .reset(reset), .StallE(StallE), .FlushE(FlushE),
        .CtrlD(CtrlD), .CondD(CondD), .FlagWriteD(FlagWriteD), .ALUFlagsE(ALUFlagsE),
        .CtrlE(d3_ctrl_e), .CtrlPipe(d3_pipe), .CondExE(d3_cond), .FlagsE(d3_flags),
        .BranchTakenD(d3_br), .PCWrPendingF(d3_pend)
    );

    cond_ctrl_pipe #(.CTRL_W(16), .DEPTH(2)) u_d2 (
        .clk(clk), .reset(reset), .StallE(StallE), .FlushE(FlushE),
        .CtrlD(CtrlD16), .CondD(CondD), .FlagWriteD(FlagWriteD), .ALUFlagsE(ALUFlagsE),
        .CtrlE(d2_ctrl_e), .CtrlPipe(d2_pipe), .CondExE(d2_cond), .FlagsE(d2_flags),
        .BranchTakenD(d2_br), .PCWrPendingF(d2_pend)
    );

    cond_ctrl_pipe #(.CTRL_W(16), .DEPTH(8)) u_d8 (
        .clk(clk), .reset(reset), .StallE(StallE), .FlushE(FlushE),
        .CtrlD(CtrlD16), .CondD(CondD), .FlagWriteD(FlagWriteD), .ALUFlagsE(ALUFlagsE),
        .CtrlE(d8_ctrl_e), .CtrlPipe(d8_pipe), .CondExE(d8_cond), .FlagsE(d8_flags),
        .BranchTakenD(d8_br), .PCWrPendingF(d8_pend)
    );

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("check %s ok (%0h)", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0]  flag_vals [3];
        logic [15:0] masks [3];
        logic [15:0] m;

        flag_vals = '{4'b0100, 4'b1010, 4'b0011};
        masks     = '{16'hE6A9, 16'hE996, 16'hE966};
`ifdef COND_EARLY_BRANCH_EN
        exp_br = 1'b1;
`else
        exp_br = 1'b0;
`endif

        // Reset with busy inputs and stall/flush active: reset must dominate.
        reset = 1'b1; StallE = 1'b1; FlushE = 1'b1;
        CtrlD = 8'hAA; CondD = 4'hE; FlagWriteD = 2'b11; ALUFlagsE = 4'hF;
        tick(); tick();
        check_eq("rst_ctrl_e", d3_ctrl_e, 8'h00);
        check_eq("rst_pipe",   d3_pipe, 16'h0000);
        check_eq("rst_flags",  d3_flags, 4'h0);
        check_eq("rst_condex", d3_cond, 1'b0);

        // Fill: one PC-writing token, then bubbles; observe latency on all three depths.
        reset = 1'b0; StallE = 1'b0; FlushE = 1'b0;
        FlagWriteD = 2'b00; ALUFlagsE = 4'h0;
        CtrlD = 8'h05; CondD = 4'hE;
        #1;
        for (int c = 0; c <= 8; c++) begin
            if (c > 0) begin
                tick();
                CtrlD = 8'h00; CondD = 4'h0;
                #1;
            end
            check_eq($sformatf("fill_d3_last_c%0d", c), d3_pipe[15:8], (c == 3) ? 8'h05 : 8'h00);
            check_eq($sformatf("fill_d3_pend_c%0d", c), d3_pend, (c < 3));
            check_eq($sformatf("fill_d2_last_c%0d", c), d2_pipe[15:0], (c == 2) ? 16'h0005 : 16'h0000);
            check_eq($sformatf("fill_d2_pend_c%0d", c), d2_pend, (c < 2));
            check_eq($sformatf("fill_d8_last_c%0d", c), d8_pipe[96 +: 16], (c == 8) ? 16'h0005 : 16'h0000);
            check_eq($sformatf("fill_d8_pend_c%0d", c), d8_pend, (c < 8));
            if (c == 2) check_eq("fill_d3_stage1", d3_pipe[7:0], 8'h05);
        end

        // Gating: EQ with Z=0 fails, low nibble of the bundle is cleared.
        CtrlD = 8'hFF; CondD = 4'h0; FlagWriteD = 2'b00;
        tick();
        check_eq("gate_ctrl_e", d3_ctrl_e, 8'hFF);
        check_eq("gate_condex", d3_cond, 1'b0);
        CtrlD = 8'h00; CondD = 4'hE;
        tick();
        check_eq("gate_stage1", d3_pipe[7:0], 8'hF0);

        // Flags: an AL instruction writes NZCV=0100, a following EQ passes.
        CtrlD = 8'h00; CondD = 4'hE; FlagWriteD = 2'b11;
        tick();
        ALUFlagsE = 4'b0100; CtrlD = 8'h10; CondD = 4'h0; FlagWriteD = 2'b00;
        tick();
        check_eq("flag_write", d3_flags, 4'b0100);
        check_eq("flag_eq_pass", d3_cond, 1'b1);
        ALUFlagsE = 4'hF; CondD = 4'hE;
        tick();
        check_eq("flag_no_write", d3_flags, 4'b0100);

        // Condition table: load flags, then every condition code in turn.
        for (int t = 0; t < 3; t++) begin
            m = masks[t];
            CtrlD = 8'h00; CondD = 4'hE; FlagWriteD = 2'b11;
            tick();
            ALUFlagsE = flag_vals[t]; FlagWriteD = 2'b00; CondD = 4'h0;
            tick();
            check_eq($sformatf("tbl%0d_flags", t), d3_flags, flag_vals[t]);
            for (int i = 0; i < 16; i++) begin
                if (i > 0) begin
                    CondD = 4'(i);
                    tick();
                end
                check_eq($sformatf("tbl%0d_cond%0d", t, i), d3_cond, m[i]);
            end
        end
        ALUFlagsE = 4'h0;

        // Stall: E held, stage 1 bubbles, flags frozen; then a single update on release.
        CtrlD = 8'h33; CondD = 4'hE; FlagWriteD = 2'b11;
        tick();
        StallE = 1'b1; ALUFlagsE = 4'b1001; CtrlD = 8'h44; CondD = 4'hE; FlagWriteD = 2'b00;
        for (int s = 0; s < 2; s++) begin
            tick();
            check_eq($sformatf("stall%0d_ctrl_e", s), d3_ctrl_e, 8'h33);
            check_eq($sformatf("stall%0d_stage1", s), d3_pipe[7:0], 8'h00);
            check_eq($sformatf("stall%0d_flags", s), d3_flags, 4'b0011);
        end
        check_eq("stall_stage2", d3_pipe[15:8], 8'h00);
        StallE = 1'b0;
        tick();
        check_eq("unstall_ctrl_e", d3_ctrl_e, 8'h44);
        check_eq("unstall_stage1", d3_pipe[7:0], 8'h33);
        check_eq("unstall_flags", d3_flags, 4'b1001);
        StallE = 1'b1; FlushE = 1'b1;
        tick();
        check_eq("flush_ctrl_e", d3_ctrl_e, 8'h00);
        check_eq("flush_stage1", d3_pipe[7:0], 8'h44);
        check_eq("flush_flags", d3_flags, 4'b1001);

        // Reset in the middle of a stall clears everything.
        StallE = 1'b0; FlushE = 1'b0; CtrlD = 8'h77; CondD = 4'hE;
        tick();
        check_eq("pre_rst_ctrl_e", d3_ctrl_e, 8'h77);
        StallE = 1'b1; reset = 1'b1;
        tick();
        check_eq("midrst_ctrl_e", d3_ctrl_e, 8'h00);
        check_eq("midrst_pipe", d3_pipe, 16'h0000);
        check_eq("midrst_flags", d3_flags, 4'h0);
        check_eq("midrst_condex", d3_cond, 1'b0);
        reset = 1'b0; StallE = 1'b0;

        // Early branch: E sets Z while D holds a BEQ.
        CtrlD = 8'h00; CondD = 4'hE; FlagWriteD = 2'b10;
        tick();
        ALUFlagsE = 4'b0100; CtrlD = 8'h02; CondD = 4'h0; FlagWriteD = 2'b00;
        #1;
        check_eq("early_branch", d3_br, exp_br);
        check_eq("early_pend", d3_pend, 1'b0);
        tick();
        check_eq("early_flags", d3_flags, 4'b0100);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
